// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared sequencer state type and core-wide constants
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } seq_state_t;

  localparam int         REG_ADDR_W = 5;
  localparam logic [6:0] OPC_HALT   = 7'b1111111;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detect between EX load and ID sources
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic                  load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a hazard
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - stall/flush/halt sequencer; PIPELINE_PERF_CNT_EN enables perf counters
module pipeline_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_halt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  resume,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  halted,
  output logic [1:0]            state,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  seq_state_t       state_q;
  seq_state_t       next_state;
  logic [CNT_W-1:0] drain_cnt;
  logic             halted_q;
  logic             load_use;

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .load_use    (load_use)
  );

  // Default is the freeze pattern: hold PC and IF/ID, bubble into EX
  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b1;
    next_state = state_q;
    if (reset) begin
      ifid_flush = 1'b1;
      next_state = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
          end else if (load_use) begin
            next_state = RUN;
          end else if (id_halt) begin
            next_state = DRAIN;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            idex_flush = 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt == CNT_LAST) next_state = HALTED;
        end
        HALTED: begin
          // HALT+4 in IF overwrites the parked HALT; ID/EX still takes a bubble
          if (resume) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            next_state = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      drain_cnt <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q  <= next_state;
      halted_q <= (next_state == HALTED);
      if (state_q == RUN && next_state == DRAIN) begin
        drain_cnt <= '0;
      end else if (state_q == DRAIN) begin
        drain_cnt <= drain_cnt + CNT_W'(1);
      end
    end
  end

  assign halted = halted_q;
  assign state  = state_q;

`ifdef PIPELINE_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (state_q == RUN) begin
      if (ex_branch_taken) flush_q <= flush_q + 32'd1;
      else if (load_use)   stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - directed and random checks of pipeline_sequencer against a reference model
module tb_pipeline_sequencer;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_halt, ex_mem_read, ex_branch_taken, resume;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, halted;
  logic [1:0]  state;
  logic [31:0] stall_cycles, flush_events;

  int total = 0;
  int bad   = 0;

  // reference model: mode 0 run, 1 drain, 2 halted; drain_left counts remaining bubble cycles
  int          m_mode;
  int          m_drain_left;
  int unsigned m_stalls;
  int unsigned m_flushes;

  pipeline_sequencer #(.DRAIN_CYCLES(D)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_halt         (id_halt),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .resume          (resume),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .halted          (halted),
    .state           (state),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs after negedge, check outputs, then advance model at posedge
  task automatic cycle(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic halt, input logic mr, input logic [4:0] rd,
                       input logic br, input logic res);
    logic e_pw, e_iw, e_if, e_xf, lu;
    @(negedge clk);
    reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_halt = halt;
    ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br; resume = res;
    #1;
    lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
    e_pw = 0; e_iw = 0; e_if = 0; e_xf = 1;
    if (rst) begin
      e_if = 1;
    end else if (m_mode == 0) begin
      if (br) begin e_pw = 1; e_iw = 1; e_if = 1; end
      else if (!lu && !halt) begin e_pw = 1; e_iw = 1; e_xf = 0; end
    end else if (m_mode == 2 && res) begin
      e_pw = 1; e_iw = 1;
    end
    chk("pc_write", 32'(pc_write), 32'(e_pw));
    chk("ifid_write", 32'(ifid_write), 32'(e_iw));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_if));
    chk("idex_flush", 32'(idex_flush), 32'(e_xf));
    if (!rst) begin
      chk("state", 32'(state), 32'(m_mode));
      chk("halted", 32'(halted), 32'(m_mode == 2));
      chk("stall_cycles", stall_cycles, m_stalls);
      chk("flush_events", flush_events, m_flushes);
    end
    if (rst) begin
      m_mode = 0; m_drain_left = 0; m_stalls = 0; m_flushes = 0;
    end else if (m_mode == 0) begin
      if (br) begin
`ifdef PIPELINE_PERF_CNT_EN
        m_flushes++;
`endif
      end else if (lu) begin
`ifdef PIPELINE_PERF_CNT_EN
        m_stalls++;
`endif
      end else if (halt) begin
        m_mode = 1; m_drain_left = D;
      end
    end else if (m_mode == 1) begin
      m_drain_left--;
      if (m_drain_left == 0) m_mode = 2;
    end else if (res) begin
      m_mode = 0;
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic res);
    cycle(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, res);
  endtask

  initial begin
    reset = 1; id_rs1 = 0; id_rs2 = 0; id_halt = 0;
    ex_mem_read = 0; ex_rd = 0; ex_branch_taken = 0; resume = 0;
    m_mode = 0; m_drain_left = 0; m_stalls = 0; m_flushes = 0;

    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    idle(0);

    // load-use on rs1, then x0 load that must not stall
    cycle(0, 5'd5, 5'd7, 0, 1, 5'd5, 0, 0);
    cycle(0, 5'd0, 5'd3, 0, 1, 5'd0, 0, 0);
    cycle(0, 5'd9, 5'd6, 0, 1, 5'd6, 0, 0);
    idle(0);

    // resume outside HALTED is ignored and not remembered
    idle(1);

    // halt, drain with noise on ignored inputs, park, resume
    cycle(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0);
    cycle(0, 5'd4, 5'd4, 0, 1, 5'd4, 1, 1);
    cycle(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1);
    idle(0);
    idle(0);
    idle(0);
    idle(1);
    idle(0);

    // halt together with taken branch: discarded
    cycle(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0);
    idle(0);

    // halt together with load-use: stall first, then drain
    cycle(0, 5'd8, 5'd3, 1, 1, 5'd3, 0, 0);
    cycle(0, 5'd8, 5'd3, 1, 0, 5'd3, 0, 0);
    idle(0);
    idle(0);
    idle(0);
    idle(0);
    idle(1);

    // reset in mid-drain
    cycle(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0);
    idle(0);
    idle(0);
    cycle(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0);
    idle(0);

    // random traffic with small register space to provoke hazards
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
